// File: rtl/vga_scan_if.sv
// Scan-timing bundle from vga_scan to its consumers (renderers and VGA connector).
// With VGA_SCAN_BLANK_EN defined the bundle also carries the renderer colour in and blanked colour out.
interface vga_scan_if;
  logic       flash_en;
  logic       pix_en;
  logic [9:0] X;
  logic [9:0] Y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;
  logic       off;
`ifdef VGA_SCAN_BLANK_EN
  logic [8:0] rgb_in;
  logic [8:0] rgb_out;
`endif

  modport master (
    input  flash_en,
`ifdef VGA_SCAN_BLANK_EN
    input  rgb_in,
    output rgb_out,
`endif
    output pix_en, X, Y, active, hsync, vsync, frame_tick, off
  );

  modport slave (
    output flash_en,
`ifdef VGA_SCAN_BLANK_EN
    output rgb_in,
    input  rgb_out,
`endif
    input  pix_en, X, Y, active, hsync, vsync, frame_tick, off
  );
endinterface

// File: rtl/vga_scan.sv
// VGA raster timing: pixel strobe, X/Y scan counters, syncs, frame tick and flash phase.
// Optional VGA_SCAN_BLANK_EN adds a blanked colour path with syncs delayed one pixel to match.
module vga_scan #(
  parameter int CLK_DIV      = 4,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int FLASH_FRAMES = 30
) (
  input logic        clk,
  input logic        rst,
  vga_scan_if.master bus
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FL_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_FRAMES - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] X_VIS  = 10'(H_VIS);
  localparam logic [9:0] Y_VIS  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_nxt;
  logic [9:0]       x_q, y_q, x_nxt, y_nxt;
  logic             pix_q, act_q, hs_q, vs_q, tick_q, off_q;
  logic [FL_W-1:0]  flash_q;
  logic             at_frame_end;

  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    x_nxt   = x_q;
    y_nxt   = y_q;
    if (pix_q) begin
      if (x_q == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_nxt = x_q + 10'd1;
      end
    end
  end

  assign at_frame_end = pix_q && (x_q == X_LAST) && (y_q == Y_LAST);

  // Decodes come from the next-state counters so they switch on the same edge as X/Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      pix_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      act_q   <= 1'b1;
      tick_q  <= 1'b0;
      flash_q <= '0;
      off_q   <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      pix_q  <= (div_nxt == DIV_LAST);
      x_q    <= x_nxt;
      y_q    <= y_nxt;
      hs_q   <= !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
      vs_q   <= !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
      act_q  <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
      tick_q <= at_frame_end;
      if (!bus.flash_en) begin
        flash_q <= '0;
        off_q   <= 1'b0;
      end else if (tick_q) begin
        if (flash_q == FL_LAST) begin
          flash_q <= '0;
          off_q   <= !off_q;
        end else begin
          flash_q <= flash_q + 1'b1;
        end
      end
    end
  end

  assign bus.pix_en     = pix_q;
  assign bus.X          = x_q;
  assign bus.Y          = y_q;
  assign bus.active     = act_q;
  assign bus.frame_tick = tick_q;
  assign bus.off        = off_q;

`ifdef VGA_SCAN_BLANK_EN
  logic [8:0] rgb_q;
  logic       hs_d, vs_d;

  // Colour and syncs sampled together so the connector sees them on the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
    end else if (pix_q) begin
      rgb_q <= act_q ? bus.rgb_in : '0;
      hs_d  <= hs_q;
      vs_d  <= vs_q;
    end
  end

  assign bus.rgb_out = rgb_q;
  assign bus.hsync   = hs_d;
  assign bus.vsync   = vs_d;
`else
  assign bus.hsync   = hs_q;
  assign bus.vsync   = vs_q;
`endif
endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan: a CLK_DIV=4 instance with full line timing and a short frame,
// and a CLK_DIV=1 instance that exercises sync widths, line length and the flash phase.
`timescale 1ns/1ps
module tb_vga_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_full, rst_fast;
  logic mon_full, mon_fast;
  int   errors = 0;
  int   checks = 0;
  int   nz_pix;

  vga_scan_if bus_full();
  vga_scan_if bus_fast();

  vga_scan #(.CLK_DIV(4), .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FLASH_FRAMES(2))
    u_full (.clk(clk), .rst(rst_full), .bus(bus_full));
  vga_scan #(.CLK_DIV(1), .V_VIS(2), .V_FP(1), .V_SYNC(2), .V_BP(1), .FLASH_FRAMES(2))
    u_fast (.clk(clk), .rst(rst_fast), .bus(bus_fast));

  typedef struct {
    int n;
    int x;
    int y;
    bit hs;
    bit vs;
    bit act;
  } pix_t;

  pix_t pixq[$];
  int   hwq[$];
  int   vwq[$];
  int   lnq[$];
  int   offq[$];

  // u_full geometry: 800 pixels per line, 8 lines (4 visible, vsync on lines 5..6).
  function automatic pix_t model_full(int n);
    pix_t p;
    p.n   = n;
    p.x   = n % 800;
    p.y   = (n / 800) % 8;
    p.hs  = !((p.x >= 656) && (p.x < 752));
    p.vs  = !((p.y >= 5) && (p.y < 7));
    p.act = (p.x < 640) && (p.y < 4);
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_pixels(input int count);
    pixq.delete();
    for (int i = 0; i < count; i++) pixq.push_back(model_full(i));
  endtask

  function automatic logic [31:0] reset_pack(input logic [9:0] x, input logic [9:0] y,
                                             input logic hs, input logic vs, input logic act,
                                             input logic off, input logic pe, input logic ft);
    return {6'd0, x, y, hs, vs, act, off, pe, ft};
  endfunction

  // Monitor: pops expectations whenever the DUTs present a strobe, pulse edge or frame tick.
  initial begin : monitor
    pix_t e;
    int   gap, cyc, last_tick, hcnt, vcnt, lcnt;
    bit   first, tick_due, was_full, was_fast, lvalid, tick_prev;
`ifdef VGA_SCAN_BLANK_EN
    pix_t prev;
`endif
    was_full = 1'b0;
    was_fast = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_full) begin
        if (!was_full) begin
          gap = 0; cyc = 0; first = 1'b1; tick_due = 1'b0; last_tick = -1;
`ifdef VGA_SCAN_BLANK_EN
          prev.hs = 1'b1; prev.vs = 1'b1; prev.act = 1'b0;
`endif
        end
        gap++;
        cyc++;
        if (tick_due || bus_full.frame_tick)
          check("frame_tick", 32'(bus_full.frame_tick), 32'(tick_due));
        if (bus_full.frame_tick) begin
          if (last_tick >= 0) check("frame_period", 32'(cyc - last_tick), 32'd25600);
          last_tick = cyc;
        end
        tick_due = 1'b0;
        if (bus_full.pix_en && pixq.size() > 0) begin
          e = pixq.pop_front();
          check("strobe_gap", 32'(gap), first ? 32'd3 : 32'd4);
          first = 1'b0;
          gap   = 0;
`ifdef VGA_SCAN_BLANK_EN
          check("pixel", {9'd0, bus_full.X, bus_full.Y, bus_full.hsync, bus_full.vsync, bus_full.active},
                {9'd0, 10'(e.x), 10'(e.y), prev.hs, prev.vs, e.act});
          check("rgb_out", {23'd0, bus_full.rgb_out}, prev.act ? 32'h1FF : 32'h0);
          prev = e;
`else
          check("pixel", {9'd0, bus_full.X, bus_full.Y, bus_full.hsync, bus_full.vsync, bus_full.active},
                {9'd0, 10'(e.x), 10'(e.y), e.hs, e.vs, e.act});
`endif
          tick_due = ((e.n % 6400) == 6399);
        end
      end
      was_full = mon_full;

      if (mon_fast) begin
        if (!was_fast) begin
          nz_pix = 0; hcnt = 0; vcnt = 0; lcnt = 0; lvalid = 1'b0; tick_prev = 1'b0;
        end
        if (!bus_fast.pix_en) nz_pix++;
        if (!bus_fast.hsync) hcnt++;
        else if (hcnt > 0) begin
          if (hwq.size() > 0) check("hsync_width", 32'(hcnt), 32'(hwq.pop_front()));
          hcnt = 0;
        end
        if (!bus_fast.vsync) vcnt++;
        else if (vcnt > 0) begin
          if (vwq.size() > 0) check("vsync_width", 32'(vcnt), 32'(vwq.pop_front()));
          vcnt = 0;
        end
        lcnt++;
        if (bus_fast.pix_en && bus_fast.X == 10'd0) begin
          if (lvalid && lnq.size() > 0) check("line_length", 32'(lcnt), 32'(lnq.pop_front()));
          lvalid = 1'b1;
          lcnt   = 0;
        end
        if (tick_prev && offq.size() > 0)
          check("off_after_tick", 32'(bus_fast.off), 32'(offq.pop_front()));
        tick_prev = bus_fast.frame_tick;
      end
      was_fast = mon_fast;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    rst_full = 1'b1;
    rst_fast = 1'b1;
    mon_full = 1'b0;
    mon_fast = 1'b0;
    nz_pix   = 0;
    bus_full.flash_en = 1'b0;
    bus_fast.flash_en = 1'b1;
`ifdef VGA_SCAN_BLANK_EN
    bus_full.rgb_in = 9'h1FF;
    bus_fast.rgb_in = 9'h1FF;
`endif
    push_pixels(6400);
    for (int i = 0; i < 40; i++) begin
      hwq.push_back(96);
      lnq.push_back(800);
    end
    for (int i = 0; i < 5; i++) vwq.push_back(1600);
    offq.push_back(0); offq.push_back(1); offq.push_back(1);

    repeat (3) @(negedge clk);
    #1;
    check("reset_full", reset_pack(bus_full.X, bus_full.Y, bus_full.hsync, bus_full.vsync, bus_full.active,
                                   bus_full.off, bus_full.pix_en, bus_full.frame_tick),
          reset_pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    check("reset_fast", reset_pack(bus_fast.X, bus_fast.Y, bus_fast.hsync, bus_fast.vsync, bus_fast.active,
                                   bus_fast.off, bus_fast.pix_en, bus_fast.frame_tick),
          reset_pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    #2;
    rst_full = 1'b0;
    rst_fast = 1'b0;
    mon_full = 1'b1;
    mon_fast = 1'b1;

    fork
      begin : full_thread
        // 2805 edges after release: X = 2805/4 = 701, inside the hsync pulse.
        repeat (2805) @(posedge clk);
        #2;
        check("pre_reset_xy", {9'd0, bus_full.X, bus_full.Y, bus_full.hsync, bus_full.vsync, bus_full.active},
              {9'd0, 10'd701, 10'd0, 1'b0, 1'b1, 1'b0});
        mon_full = 1'b0;
        rst_full = 1'b1;
        #1;
        check("reset_midrun", reset_pack(bus_full.X, bus_full.Y, bus_full.hsync, bus_full.vsync, bus_full.active,
                                         bus_full.off, bus_full.pix_en, bus_full.frame_tick),
              reset_pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        push_pixels(12800);
        repeat (5) @(negedge clk);
        #2;
        rst_full = 1'b0;
        mon_full = 1'b1;
        for (int i = 0; i < 60000 && pixq.size() > 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("pixel_drain", 32'(pixq.size()), 32'd0);
      end
      begin : fast_thread
        for (int i = 0; i < 30000 && offq.size() > 0; i++) @(negedge clk);
        check("flash_drain1", 32'(offq.size()), 32'd0);
        repeat (1000) @(negedge clk);
        check("off_before_drop", 32'(bus_fast.off), 32'd1);
        #2;
        bus_fast.flash_en = 1'b0;
        @(negedge clk);
        check("off_drop", 32'(bus_fast.off), 32'd0);
        repeat (6000) @(negedge clk);
        check("off_hold", 32'(bus_fast.off), 32'd0);
        #2;
        bus_fast.flash_en = 1'b1;
        offq.push_back(0); offq.push_back(1); offq.push_back(1); offq.push_back(0);
        for (int i = 0; i < 30000 && offq.size() > 0; i++) @(negedge clk);
        check("flash_drain2", 32'(offq.size()), 32'd0);
      end
    join

    check("fast_pix_gaps", 32'(nz_pix), 32'd0);
    check("hsync_seen", 32'(hwq.size()), 32'd0);
    check("vsync_seen", 32'(vwq.size()), 32'd0);
    check("lines_seen", 32'(lnq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_scan.md
Name: vga_scan

Overview:
- Upstream timing stage for the rectangle renderer: generates the pixel strobe, the raster scan coordinates X/Y, the sync pulses and the flash signal `off` for 640x480@60 VGA.
- Runs from the 100 MHz board clock and divides it down to a 25 MHz pixel rate.
- X, Y and off feed every rectangle-draw instance directly; hsync/vsync go to the VGA connector.

Parameters:
- CLK_DIV, 4, board clocks per pixel (>=1)
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- FLASH_FRAMES, 30, frames per half-period of `off`

Ports:
- clk  in  1  board clock
- rst  in  1  reset, asynchronous, active-high
- flash_en  in  1  enables flashing of `off`
- pix_en  out  1  one-clk pixel strobe
- X  out  10  horizontal count 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800
- Y  out  10  vertical count 0..V_TOT-1, where V_TOT = 525
- active  out  1  high when X<H_VIS and Y<V_VIS
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_tick  out  1  one-clk pulse at frame start
- off  out  1  flash phase to renderer (1 = hide)

Behaviour:
- Reset (async, active-high) forces:
  - divider=0, X=0, Y=0, pix_en=0, frame_tick=0, off=0, flash counter=0
  - hsync=1, vsync=1, active=1 (the decode of 0,0)
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 for one clk when divider==CLK_DIV-1; the first pix_en is the 4th clk after reset release (CLK_DIV=4).
  - CLK_DIV=1: pix_en=1 every clk after reset.
- Scan counters (update only on clk with pix_en=1):
  - X increments; at X==H_TOT-1, X→0 and Y increments.
  - At Y==V_TOT-1 together with X==H_TOT-1, Y→0.
- Decode timing:
  - hsync, vsync and active are registered from the next-state counter values, so they change on the same clk edge as X/Y. There is zero skew relative to X/Y.
  - hsync=0 iff H_VIS+H_FP <= X < H_VIS+H_FP+H_SYNC, i.e. 656..751.
  - vsync=0 iff V_VIS+V_FP <= Y < V_VIS+V_FP+V_SYNC, i.e. 490..491.
  - X/Y are raw counts outside the visible area. Consumers must qualify with active.
- frame_tick:
  - High for exactly the one clk following the edge on which (X,Y) wraps from (799,524) to (0,0).
  - Never asserted after reset alone.
  - Frame period = 800*525*CLK_DIV = 1,680,000 clk.
- Flash:
  - flash_en=0: flash counter cleared and off=0 on the next clk edge, held there.
  - flash_en=1: on each frame_tick the counter increments. When the counter==FLASH_FRAMES-1 at a frame_tick, it clears and off toggles.
  - flash_en rising mid-frame: counting starts at the next frame_tick. The first toggle comes FLASH_FRAMES ticks later.
- Reset mid-frame: all state returns to reset values immediately (async), without waiting for pix_en or the frame boundary.
- Widths: all counters are 10 bits; H_TOT and V_TOT must be <=1024. The flash counter is wide enough for FLASH_FRAMES-1.

Optional Feature:
- Macro: VGA_SCAN_BLANK_EN.
- Defined:
  - Adds input rgb_in[8:0] (renderer colour, RGBt[9:1]) and output rgb_out[8:0].
  - rgb_out is registered on pix_en: active ? rgb_in : 0.
  - hsync/vsync gain one extra pixel of delay (registered on pix_en) so they stay aligned with rgb_out.
  - Reset: rgb_out=0, delayed syncs=1.
- Undefined:
  - rgb_in and rgb_out are absent; sync timing is exactly as above.
  - Blanking is the top level's responsibility.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-run at an arbitrary clk.
  - Required: X=0, Y=0, hsync=1, vsync=1, active=1, off=0, pix_en=0 immediately, before the next edge.
  - After release, first pix_en on the 4th clk and X=1 after it.
- Horizontal timing:
  - Stimulus: free-run one line.
  - Required: hsync low for exactly 96 pix_en periods, starting where X becomes 656.
  - active falls when X becomes 640; line length 800 pixels = 3200 clk.
- Vertical timing:
  - Stimulus: free-run one frame.
  - Required: vsync low exactly while Y is 490..491 (1600 pixels).
  - frame_tick pulses once per 1,680,000 clk, each one clk after X,Y wrap to 0,0.
- Flash:
  - Stimulus: flash_en=1 with FLASH_FRAMES=2 (sim override).
  - Required: off toggles every 2nd frame_tick.
  - Dropping flash_en: off=0 on the next clk, and the toggle count restarts when re-enabled.
- CLK_DIV=1 (sim override):
  - Required: pix_en constantly 1; line = 800 clk; sync widths 96 clk and 2 lines.
- VGA_SCAN_BLANK_EN defined:
  - Stimulus: rgb_in=9'h1FF.
  - Required: rgb_out=9'h1FF while the delayed active is high, 0 when X>=640.
  - hsync falls one pixel after X becomes 656.
